// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the core-side Wishbone bridge.
package wb_bridge_pkg;

    // Bus-side sequencer states; encodings are fixed so debug taps stay stable.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } bridge_state_e;

    // Width of one posted request: {we, addr, wdata, be}.
    function automatic int entry_width(input int aw, input int dw, input int sw);
        return 32'sd1 + aw + dw + sw;
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Posted-request FIFO. Pointers carry an extra wrap bit so full and empty
// fall out of a plain pointer compare; read data is the registered head entry.
module wb_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_ptr_r;
    logic [PW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                       (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
    assign empty_o   = (wr_ptr_r == rd_ptr_r);
    assign pop_ok_s  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so push at full is still safe.
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign rdata_o   = mem_r[rd_ptr_r[PW-1:0]];

    // Advance write/read pointers on accepted push/pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/wb_core_bridge.sv
// Core-side Wishbone B4 classic master bridge: posted request FIFO, single
// outstanding bus cycle, ERR and timeout handling, registered response pulse.
module wb_core_bridge
    import wb_bridge_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 255,
    parameter bit WAIT_ACK_LOW = 1'b1,
    localparam int SW          = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          core_req_i,
    output logic          core_gnt_o,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    input  logic [SW-1:0] core_be_i,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_err_o,
    output logic          busy_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    output logic [SW-1:0] wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [DW-1:0] wb_data_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    localparam int EW = entry_width(AW, DW, SW);
    // Timer must reach TIMEOUT-1; keep at least one bit when the timeout is disabled.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic [EW-1:0] fifo_wdata_s;
    logic [EW-1:0] fifo_rdata_s;
    logic          head_we_s;
    logic [AW-1:0] head_addr_s;
    logic [DW-1:0] head_wdata_s;
    logic [SW-1:0] head_be_s;
    logic          timeout_s;
    logic          bus_term_s;
    logic          resp_err_s;

    bridge_state_e state_r;
    logic [TW-1:0] timer_r;
    logic [AW-1:0] wb_addr_r;
    logic [DW-1:0] wb_data_r;
    logic [SW-1:0] wb_sel_r;
    logic          wb_we_r;
    logic          wb_cyc_r;
    logic          wb_stb_r;
    logic          rvalid_r;
    logic          rerr_r;
    logic [DW-1:0] rdata_r;

    assign fifo_wdata_s = {core_we_i, core_addr_i, core_wdata_i, core_be_i};
    assign {head_we_s, head_addr_s, head_wdata_s, head_be_s} = fifo_rdata_s;

    // Grant depends only on FIFO occupancy, so the push qualifier is just the handshake.
    assign push_s     = core_req_i & ~fifo_full_s;
    assign pop_s      = (state_r == ST_IDLE) & ~fifo_empty_s;
    assign timeout_s  = (TIMEOUT > 0) && (timer_r == TIMER_LAST);
    assign bus_term_s = wb_ack_i | wb_err_i | timeout_s;
    assign resp_err_s = wb_err_i | timeout_s;

    wb_req_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Bus sequencer: launches the head request, times it, and emits the response pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            wb_addr_r <= {AW{1'b0}};
            wb_data_r <= {DW{1'b0}};
            wb_sel_r  <= {SW{1'b0}};
            wb_we_r   <= 1'b0;
            wb_cyc_r  <= 1'b0;
            wb_stb_r  <= 1'b0;
            rvalid_r  <= 1'b0;
            rerr_r    <= 1'b0;
            rdata_r   <= {DW{1'b0}};
        end else begin
            rvalid_r <= 1'b0;
            rerr_r   <= 1'b0;
            rdata_r  <= {DW{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        wb_addr_r <= head_addr_s;
                        wb_data_r <= head_wdata_s;
                        wb_sel_r  <= head_be_s;
                        wb_we_r   <= head_we_s;
                        wb_cyc_r  <= 1'b1;
                        wb_stb_r  <= 1'b1;
                        timer_r   <= {TW{1'b0}};
                        state_r   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_term_s) begin
                        wb_cyc_r <= 1'b0;
                        wb_stb_r <= 1'b0;
                        wb_we_r  <= 1'b0;
                        rvalid_r <= 1'b1;
                        rerr_r   <= resp_err_s;
                        // ERR or timeout suppresses read data even if ACK came with it.
                        if (!wb_we_r && wb_ack_i && !resp_err_s) begin
                            rdata_r <= wb_data_i;
                        end
                        state_r <= WAIT_ACK_LOW ? ST_RELEASE : ST_IDLE;
                    end else if (timer_r != TIMER_MAX) begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!wb_ack_i && !wb_err_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    wb_cyc_r <= 1'b0;
                    wb_stb_r <= 1'b0;
                    wb_we_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_gnt_o    = ~fifo_full_s;
    assign busy_o        = ~fifo_empty_s | (state_r != ST_IDLE);
    assign core_rvalid_o = rvalid_r;
    assign core_rdata_o  = rdata_r;
    assign core_err_o    = rerr_r;
    assign wb_addr_o     = wb_addr_r;
    assign wb_data_o     = wb_data_r;
    assign wb_sel_o      = wb_sel_r;
    assign wb_we_o       = wb_we_r;
    assign wb_cyc_o      = wb_cyc_r;
    assign wb_stb_o      = wb_stb_r;

endmodule

// File: tb/tb_wb_core_bridge.sv
// Directed bench for wb_core_bridge: instance A uses default timeout with
// ACK-release wait, instance B uses TIMEOUT=8 and skips the release state.
module tb_wb_core_bridge;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;

    logic        req_a = 1'b0, we_a = 1'b0;
    logic [31:0] addr_a = 32'h0, wdata_a = 32'h0, din_a = 32'h0;
    logic [3:0]  be_a = 4'h0;
    logic        ack_a = 1'b0, err_a = 1'b0;
    logic        gnt_a, rvalid_a, cerr_a, busy_a, wbwe_a, cyc_a, stb_a;
    logic [31:0] rdata_a, wbaddr_a, dout_a;
    logic [3:0]  sel_a;

    logic        req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_b = 32'h0, wdata_b = 32'h0, din_b = 32'h0;
    logic [3:0]  be_b = 4'h0;
    logic        ack_b = 1'b0, err_b = 1'b0;
    logic        gnt_b, rvalid_b, cerr_b, busy_b, wbwe_b, cyc_b, stb_b;
    logic [31:0] rdata_b, wbaddr_b, dout_b;
    logic [3:0]  sel_b;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    wb_core_bridge #(.AW(32), .DW(32), .FIFO_DEPTH(4), .TIMEOUT(255), .WAIT_ACK_LOW(1'b1)) u_dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .core_req_i(req_a), .core_gnt_o(gnt_a), .core_we_i(we_a), .core_addr_i(addr_a),
        .core_wdata_i(wdata_a), .core_be_i(be_a), .core_rvalid_o(rvalid_a),
        .core_rdata_o(rdata_a), .core_err_o(cerr_a), .busy_o(busy_a),
        .wb_addr_o(wbaddr_a), .wb_data_o(dout_a), .wb_sel_o(sel_a), .wb_we_o(wbwe_a),
        .wb_cyc_o(cyc_a), .wb_stb_o(stb_a), .wb_data_i(din_a), .wb_ack_i(ack_a), .wb_err_i(err_a)
    );

    wb_core_bridge #(.AW(32), .DW(32), .FIFO_DEPTH(4), .TIMEOUT(8), .WAIT_ACK_LOW(1'b0)) u_dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .core_req_i(req_b), .core_gnt_o(gnt_b), .core_we_i(we_b), .core_addr_i(addr_b),
        .core_wdata_i(wdata_b), .core_be_i(be_b), .core_rvalid_o(rvalid_b),
        .core_rdata_o(rdata_b), .core_err_o(cerr_b), .busy_o(busy_b),
        .wb_addr_o(wbaddr_b), .wb_data_o(dout_b), .wb_sel_o(sel_b), .wb_we_o(wbwe_b),
        .wb_cyc_o(cyc_b), .wb_stb_o(stb_b), .wb_data_i(din_b), .wb_ack_i(ack_b), .wb_err_i(err_b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        req_a = req; we_a = we; addr_a = addr; wdata_a = wdata; be_a = be;
    endtask

    initial begin : main
        int n;
        int rv;
        int issued;
        int cnt;
        int seen;
        logic acc;

        // ---------------- reset ----------------
        repeat (3) step();
        rst_n_i = 1'b1;
        step();
        check_eq("rst_gnt", {31'd0, gnt_a}, 32'd1);
        check_eq("rst_cyc", {30'd0, cyc_a, stb_a}, 32'd0);
        check_eq("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_wbaddr", wbaddr_a, 32'd0);

        // ---------------- 1: single read, 3 wait states ----------------
        drive_a(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        step();                                     // edge0: push
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_eq("t1_cyc_e0", {31'd0, cyc_a}, 32'd0);
        check_eq("t1_busy_e0", {31'd0, busy_a}, 32'd1);
        step();                                     // edge1: launch
        check_eq("t1_cycstb_e1", {30'd0, cyc_a, stb_a}, 32'd3);
        check_eq("t1_addr", wbaddr_a, 32'h0000_0010);
        check_eq("t1_we", {31'd0, wbwe_a}, 32'd0);
        check_eq("t1_sel", {28'd0, sel_a}, 32'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t1_cyc_wait", {31'd0, cyc_a}, 32'd1);
            check_eq("t1_rvalid_wait", {31'd0, rvalid_a}, 32'd0);
        end
        ack_a = 1'b1; din_a = 32'hDEAD_BEEF;
        step();                                     // edge5: ACK sampled
        ack_a = 1'b0; din_a = 32'h0;
        check_eq("t1_cyc_end", {30'd0, cyc_a, stb_a}, 32'd0);
        check_eq("t1_rvalid", {31'd0, rvalid_a}, 32'd1);
        check_eq("t1_rdata", rdata_a, 32'hDEAD_BEEF);
        check_eq("t1_err", {31'd0, cerr_a}, 32'd0);
        step();
        check_eq("t1_rvalid_pulse", {31'd0, rvalid_a}, 32'd0);
        check_eq("t1_busy_done", {31'd0, busy_a}, 32'd0);

        // ---------------- 2: burst of 6 writes, slave silent 10 cycles ----------------
        n = 0; rv = 0; issued = 0;
        for (int c = 0; c < 120 && rv < 6; c++) begin
            if (n < 6) drive_a(1'b1, 1'b1, 32'h0000_0100 + 32'(4 * n), 32'h1111_0000 + 32'(n), 4'hF);
            else       drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            acc = req_a & gnt_a;
            ack_a = cyc_a & stb_a & (c >= 10);
            if (ack_a) begin
                check_eq("t2_addr", wbaddr_a, 32'h0000_0100 + 32'(4 * issued));
                check_eq("t2_wdata", dout_a, 32'h1111_0000 + 32'(issued));
                check_eq("t2_we", {31'd0, wbwe_a}, 32'd1);
                issued++;
            end
            if (c == 5) begin
                check_eq("t2_gnt_full", {31'd0, gnt_a}, 32'd0);
                check_eq("t2_accepted_at_full", 32'(n), 32'd5);
            end
            step();
            if (acc) n++;
            if (rvalid_a) begin
                rv++;
                check_eq("t2_err", {31'd0, cerr_a}, 32'd0);
            end
        end
        ack_a = 1'b0;
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_eq("t2_rvalid_count", 32'(rv), 32'd6);
        check_eq("t2_issued_count", 32'(issued), 32'd6);
        repeat (2) step();
        check_eq("t2_busy_done", {31'd0, busy_a}, 32'd0);

        // ---------------- 3: ACK and ERR in the same cycle ----------------
        drive_a(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h3);
        step();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        check_eq("t3_cyc", {31'd0, cyc_a}, 32'd1);
        ack_a = 1'b1; err_a = 1'b1; din_a = 32'h1234_5678;
        step();
        ack_a = 1'b0; err_a = 1'b0; din_a = 32'h0;
        check_eq("t3_rvalid", {31'd0, rvalid_a}, 32'd1);
        check_eq("t3_err", {31'd0, cerr_a}, 32'd1);
        check_eq("t3_rdata", rdata_a, 32'd0);
        repeat (2) step();

        // ---------------- 4: timeout on instance B, then next request ----------------
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0000_0040; be_b = 4'hF;
        step();                                     // edge0: push X
        addr_b = 32'h0000_0044;
        step();                                     // edge1: launch X, push Y
        req_b = 1'b0;
        cnt = 0;
        for (int g = 0; g < 30 && cyc_b; g++) begin
            cnt++;
            step();
        end
        check_eq("t4_req_cycles", 32'(cnt), 32'd8);
        check_eq("t4_rvalid", {31'd0, rvalid_b}, 32'd1);
        check_eq("t4_err", {31'd0, cerr_b}, 32'd1);
        check_eq("t4_rdata", rdata_b, 32'd0);
        step();                                     // next request launches right away
        check_eq("t4_next_cyc", {31'd0, cyc_b}, 32'd1);
        check_eq("t4_next_addr", wbaddr_b, 32'h0000_0044);
        check_eq("t4_rvalid_pulse", {31'd0, rvalid_b}, 32'd0);
        ack_b = 1'b1; din_b = 32'hCAFE_F00D;
        step();
        ack_b = 1'b0; din_b = 32'h0;
        check_eq("t4_next_rvalid", {31'd0, rvalid_b}, 32'd1);
        check_eq("t4_next_err", {31'd0, cerr_b}, 32'd0);
        check_eq("t4_next_rdata", rdata_b, 32'hCAFE_F00D);
        step();
        check_eq("t4_busy_done", {31'd0, busy_b}, 32'd0);

        // ---------------- 5: ACK held 3 extra cycles with release wait ----------------
        drive_a(1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_0001, 4'hF);
        step();                                     // edge0: push P
        drive_a(1'b1, 1'b1, 32'h0000_0084, 32'hAAAA_0002, 4'hC);
        step();                                     // edge1: launch P, push Q
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ack_a = 1'b1;
        step();                                     // edge2: terminate P
        check_eq("t5_rvalid", {31'd0, rvalid_a}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_hold_cyc", {31'd0, cyc_a}, 32'd0);
            check_eq("t5_hold_rvalid", {31'd0, rvalid_a}, 32'd0);
        end
        ack_a = 1'b0;
        step();                                     // leaves RELEASE
        check_eq("t5_release_cyc", {31'd0, cyc_a}, 32'd0);
        step();                                     // launches Q
        check_eq("t5_next_cyc", {31'd0, cyc_a}, 32'd1);
        check_eq("t5_next_addr", wbaddr_a, 32'h0000_0084);
        check_eq("t5_next_sel", {28'd0, sel_a}, 32'hC);
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        repeat (2) step();

        // ---------------- 6: reset mid-REQ with 3 queued ----------------
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b1, 32'h0000_0200 + 32'(4 * i), 32'hBBBB_0000 + 32'(i), 4'hF);
            step();
        end
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check_eq("t6_cyc_before", {31'd0, cyc_a}, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("t6_cycstb_async", {30'd0, cyc_a, stb_a}, 32'd0);
        repeat (2) step();
        rst_n_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rvalid_a || cyc_a) seen++;
        end
        check_eq("t6_no_activity", 32'(seen), 32'd0);
        check_eq("t6_busy", {31'd0, busy_a}, 32'd0);
        check_eq("t6_gnt", {31'd0, gnt_a}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
